// File: rtl/rpc_stb_cmd_decoder.sv
// Purpose: small registered first-word-fall-through FIFO for decoded command words.
// Latency: a push is visible at the head one cycle later; the head is a register read.
// Backpressure: push must be gated by full (or full with a same-cycle pop); pop only when not empty.
module rpc_stb_cmd_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             head_vld,
    output logic             full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;

    assign head_vld = (count != '0);
    assign full     = (count == (PW+1)'(DEPTH));
    assign head_dat = mem[rd_ptr];

    // Storage write; when full with a same-cycle pop, wr_ptr == rd_ptr and the popped slot is reused.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// Purpose: deserialize the CS_n-framed STB command stream into command words and queue them.
// Latency: last bit sampled in cycle N -> cmd_valid_o in cycle N+2 when the queue was empty.
// Backpressure: valid/ready at the output; a frame completing into a full queue is dropped with overflow_o.
module rpc_stb_cmd_decoder #(
    parameter int DRAM_CMD_WIDTH = 32,
    parameter int FIFO_DEPTH     = 2,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      rpc_cs_ni,
    input  logic                      rpc_stb_i,
    output logic                      cmd_valid_o,
    input  logic                      cmd_ready_i,
    output logic [DRAM_CMD_WIDTH-1:0] cmd_o,
    output logic [3:0]                cmd_opcode_o,
    output logic [1:0]                cmd_bank_o,
    output logic [12:0]               cmd_addr_o,
    output logic [5:0]                cmd_len_o,
    output logic                      cmd_illegal_o,
    output logic                      frame_err_o,
    output logic                      overflow_o,
    output logic [CNT_WIDTH-1:0]      frame_cnt_o,
    output logic                      busy_o
);
    localparam int W  = DRAM_CMD_WIDTH;
    localparam int BW = $clog2(W + 1);

    // GAP is the post-frame wait while CS_n is still held low; it behaves like IDLE for framing.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  sreg;
    logic [BW-1:0] bit_cnt;

    logic          load_first;
    logic          shift_en;
    logic          abort_err;
    logic          gap_err;
    logic          push_req;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_vld;
    logic [W-1:0]  fifo_head;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-cycle control strobes for the shifter and the queue.
    always_comb begin
        state_nxt  = state;
        load_first = 1'b0;
        shift_en   = 1'b0;
        abort_err  = 1'b0;
        gap_err    = 1'b0;
        push_req   = 1'b0;
        case (state)
            IDLE: begin
                if (!rpc_cs_ni) begin
                    load_first = 1'b1;
                    state_nxt  = SHIFT;
                end
            end
            SHIFT: begin
                if (rpc_cs_ni) begin
                    abort_err = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    shift_en = 1'b1;
                    if (bit_cnt == BW'(W - 1)) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                push_req = 1'b1;
                if (!rpc_cs_ni) begin
                    gap_err   = 1'b1;
                    state_nxt = GAP;
                end else begin
                    state_nxt = IDLE;
                end
            end
            GAP: begin
                if (rpc_cs_ni) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift register and bit counter: MSB arrives first, every later bit enters at the LSB.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sreg    <= '0;
            bit_cnt <= '0;
        end else if (load_first) begin
            sreg    <= {{(W-1){1'b0}}, rpc_stb_i};
            bit_cnt <= BW'(1);
        end else if (shift_en) begin
            sreg    <= {sreg[W-2:0], rpc_stb_i};
            bit_cnt <= bit_cnt + BW'(1);
        end else if (abort_err || push_req) begin
            bit_cnt <= '0;
        end
    end

    // A same-cycle pop frees a slot, so a full queue still accepts the completed frame.
    assign fifo_pop  = fifo_vld && cmd_ready_i;
    assign fifo_push = push_req && (!fifo_full || fifo_pop);

    rpc_stb_cmd_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .push     (fifo_push),
        .push_dat (sreg),
        .pop      (fifo_pop),
        .head_dat (fifo_head),
        .head_vld (fifo_vld),
        .full     (fifo_full)
    );

    // Registered status pulses and the accepted-frame counter (wraps silently).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_err_o <= 1'b0;
            overflow_o  <= 1'b0;
            frame_cnt_o <= '0;
        end else begin
            frame_err_o <= abort_err || gap_err;
            overflow_o  <= push_req && !fifo_push;
            if (fifo_push) begin
                frame_cnt_o <= frame_cnt_o + CNT_WIDTH'(1);
            end
        end
    end

    // Head word and decoded fields are forced to zero whenever the queue is empty.
    assign cmd_valid_o   = fifo_vld;
    assign cmd_o         = fifo_vld ? fifo_head : '0;
    assign cmd_opcode_o  = cmd_o[W-1:W-4];
    assign cmd_bank_o    = cmd_o[W-5:W-6];
    assign cmd_addr_o    = cmd_o[W-7:W-19];
    assign cmd_len_o     = cmd_o[W-20:W-25];
    assign cmd_illegal_o = fifo_vld && cmd_opcode_o[3];
    assign busy_o        = (state == SHIFT);
endmodule

// File: tb/tb_rpc_stb_cmd_decoder.sv
// Purpose: scoreboard bench for the STB command decoder.
// Latency: checks first-valid timing, queue order, drops and error pulses.
// Backpressure: drives cmd_ready_i from the stimulus thread to exercise full/overflow cases.
module tb_rpc_stb_cmd_decoder;
    localparam int W = 32;

    logic        clk_i;
    logic        rst_ni;
    logic        rpc_cs_ni;
    logic        rpc_stb_i;
    logic        cmd_valid_o;
    logic        cmd_ready_i;
    logic [W-1:0] cmd_o;
    logic [3:0]  cmd_opcode_o;
    logic [1:0]  cmd_bank_o;
    logic [12:0] cmd_addr_o;
    logic [5:0]  cmd_len_o;
    logic        cmd_illegal_o;
    logic        frame_err_o;
    logic        overflow_o;
    logic [15:0] frame_cnt_o;
    logic        busy_o;

    rpc_stb_cmd_decoder #(
        .DRAM_CMD_WIDTH (W),
        .FIFO_DEPTH     (2),
        .CNT_WIDTH      (16)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .rpc_cs_ni     (rpc_cs_ni),
        .rpc_stb_i     (rpc_stb_i),
        .cmd_valid_o   (cmd_valid_o),
        .cmd_ready_i   (cmd_ready_i),
        .cmd_o         (cmd_o),
        .cmd_opcode_o  (cmd_opcode_o),
        .cmd_bank_o    (cmd_bank_o),
        .cmd_addr_o    (cmd_addr_o),
        .cmd_len_o     (cmd_len_o),
        .cmd_illegal_o (cmd_illegal_o),
        .frame_err_o   (frame_err_o),
        .overflow_o    (overflow_o),
        .frame_cnt_o   (frame_cnt_o),
        .busy_o        (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_cyc = 0;
    int first_valid_cyc = -1;
    int valid_cycles = 0;
    int ferr_cnt = 0;
    int ovf_cnt = 0;
    logic [W-1:0] exp_q[$];

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic [3:0] op, input logic [1:0] bk,
                                        input logic [12:0] ad, input logic [5:0] ln,
                                        input logic [6:0] rsv);
        return {op, bk, ad, ln, rsv};
    endfunction

    // Output monitor: compare the head against the scoreboard, pop on handshake, count pulses.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (cmd_valid_o) begin
                valid_cycles++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_valid", 1, 0);
                end else begin
                    check_eq("cmd_word", cmd_o, exp_q[0]);
                    check_eq("opcode", cmd_opcode_o, exp_q[0][31:28]);
                    check_eq("bank", cmd_bank_o, exp_q[0][27:26]);
                    check_eq("addr", cmd_addr_o, exp_q[0][25:13]);
                    check_eq("len", cmd_len_o, exp_q[0][12:7]);
                    check_eq("illegal", cmd_illegal_o, (exp_q[0][31:28] > 4'd7) ? 1 : 0);
                    if (cmd_ready_i) void'(exp_q.pop_front());
                end
            end else begin
                check_eq("idle_fields_zero", {cmd_o, cmd_opcode_o, cmd_len_o, 1'b0, cmd_illegal_o}, 0);
            end
            if (frame_err_o) ferr_cnt++;
            if (overflow_o) ovf_cnt++;
        end
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_i);
            #2;
        end
    endtask

    // Serialize n bits of w MSB first; bits past the word are driven as 0.
    task automatic send_bits(input logic [W-1:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            rpc_cs_ni = 1'b0;
            rpc_stb_i = (i < W) ? w[W-1-i] : 1'b0;
            if (i == 1) check_eq("busy_in_shift", busy_o, 1);
            last_cyc = cyc;
            tick(1);
        end
        rpc_cs_ni = 1'b1;
        rpc_stb_i = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] w, input bit queued);
        if (queued) exp_q.push_back(w);
        send_bits(w, W);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick(1);
        check_eq(tag, exp_q.size(), 0);
    endtask

    int fc0;
    int fe0;
    int ov0;
    logic [W-1:0] w_act;
    logic [W-1:0] w_a;
    logic [W-1:0] w_b;
    logic [W-1:0] w_c;

    initial begin
        rst_ni      = 1'b0;
        rpc_cs_ni   = 1'b1;
        rpc_stb_i   = 1'b0;
        cmd_ready_i = 1'b0;
        tick(3);
        check_eq("rst_valid", cmd_valid_o, 0);
        check_eq("rst_cmd", cmd_o, 0);
        check_eq("rst_cnt", frame_cnt_o, 0);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_pulses", {frame_err_o, overflow_o}, 0);
        rst_ni = 1'b1;
        tick(2);

        // Single ACT with ready held high: latency and one-cycle valid.
        cmd_ready_i     = 1'b1;
        first_valid_cyc = -1;
        valid_cycles    = 0;
        w_act = mk(4'h1, 2'd2, 13'h0ABC, 6'd0, 7'h00);
        send_frame(w_act, 1'b1);
        tick(6);
        check_eq("act_latency", first_valid_cyc, last_cyc + 2);
        check_eq("act_valid_cycles", valid_cycles, 1);
        check_eq("act_frame_cnt", frame_cnt_o, 1);
        check_eq("act_busy_after", busy_o, 0);

        // Three back-to-back RD frames into a stalled two-entry queue.
        cmd_ready_i = 1'b0;
        fc0 = frame_cnt_o;
        ov0 = ovf_cnt;
        send_frame(mk(4'h2, 2'd1, 13'h0100, 6'd8,  7'h55), 1'b1);
        tick(1);
        send_frame(mk(4'h2, 2'd3, 13'h1FFF, 6'd16, 7'h7F), 1'b1);
        tick(1);
        send_frame(mk(4'h2, 2'd0, 13'h0001, 6'd32, 7'h00), 1'b0);
        tick(4);
        check_eq("b2b_overflow", ovf_cnt - ov0, 1);
        check_eq("b2b_frame_cnt", frame_cnt_o, fc0 + 2);
        check_eq("b2b_queued", exp_q.size(), 2);
        cmd_ready_i = 1'b1;
        drain("b2b_drain");

        // Aborted frame, then a frame with a CS gap violation that still queues.
        fc0 = frame_cnt_o;
        fe0 = ferr_cnt;
        valid_cycles = 0;
        send_bits(mk(4'h3, 2'd1, 13'h0AAA, 6'd4, 7'h00), 17);
        tick(4);
        check_eq("abort_ferr", ferr_cnt - fe0, 1);
        check_eq("abort_no_push", frame_cnt_o, fc0);
        check_eq("abort_no_valid", valid_cycles, 0);
        exp_q.push_back(mk(4'h3, 2'd2, 13'h1555, 6'd63, 7'h2A));
        send_bits(mk(4'h3, 2'd2, 13'h1555, 6'd63, 7'h2A), W + 1);
        tick(2);
        drain("gap_drain");
        check_eq("gap_ferr", ferr_cnt - fe0, 2);
        check_eq("gap_frame_cnt", frame_cnt_o, fc0 + 1);

        // Illegal opcode is still queued and flagged.
        fc0 = frame_cnt_o;
        send_frame(mk(4'hC, 2'd1, 13'h0123, 6'd2, 7'h01), 1'b1);
        tick(2);
        drain("illegal_drain");
        check_eq("illegal_frame_cnt", frame_cnt_o, fc0 + 1);

        // Full queue with a pop on the DONE cycle of a new frame: no overflow.
        cmd_ready_i = 1'b0;
        ov0 = ovf_cnt;
        fc0 = frame_cnt_o;
        w_a = mk(4'h4, 2'd0, 13'h0010, 6'd1, 7'h00);
        w_b = mk(4'h6, 2'd1, 13'h0020, 6'd2, 7'h00);
        w_c = mk(4'h7, 2'd2, 13'h0030, 6'd3, 7'h11);
        send_frame(w_a, 1'b1);
        tick(1);
        send_frame(w_b, 1'b1);
        tick(2);
        send_frame(w_c, 1'b1);
        cmd_ready_i = 1'b1;
        tick(1);
        check_eq("full_pop_valid_held", cmd_valid_o, 1);
        drain("full_pop_drain");
        check_eq("full_pop_no_overflow", ovf_cnt - ov0, 0);
        check_eq("full_pop_frame_cnt", frame_cnt_o, fc0 + 3);

        // Reset in the middle of a frame with a word waiting at the head.
        cmd_ready_i = 1'b0;
        send_frame(mk(4'h2, 2'd2, 13'h0777, 6'd8, 7'h00), 1'b1);
        tick(3);
        fe0 = ferr_cnt;
        send_bits(mk(4'h5, 2'd0, 13'h0000, 6'd0, 7'h00), 20);
        rst_ni = 1'b0;
        exp_q.delete();
        #1;
        check_eq("midrst_valid", cmd_valid_o, 0);
        check_eq("midrst_cmd", cmd_o, 0);
        check_eq("midrst_cnt", frame_cnt_o, 0);
        check_eq("midrst_busy", busy_o, 0);
        tick(2);
        rst_ni      = 1'b1;
        cmd_ready_i = 1'b1;
        tick(2);
        send_frame(mk(4'h5, 2'd3, 13'h0042, 6'd0, 7'h00), 1'b1);
        tick(2);
        drain("ref_drain");
        check_eq("ref_frame_cnt", frame_cnt_o, 1);
        check_eq("midrst_no_ferr", ferr_cnt - fe0, 0);

        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
